// File: rtl/ctrl_tx.sv
// ctrl_tx -- serial transmitter for the analog-controls link.
// On an accepted `go` it snapshots seven control bytes, appends their XOR
// checksum and sends SYNC + 7 data + CHK as 8N1 UART frames, back to back.
//
// Ports:
//   clk, reset          system clock, async active-high reset
//   go                  start request, sampled only while idle
//   a8,a5,a4            tone-control values
//   blend,delay,feedbk  delay-control values
//   gain                gain value
//   busy                frame in progress (registered)
//   done                one-cycle pulse as the frame ends (registered)
//   CTRL_TX             serial line, idles high (registered)
module ctrl_tx #(
   parameter int         fCLK  = 50_000_000,
   parameter int         fBAUD = 115_200,
   parameter logic [7:0] SYNC  = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic [7:0] a8,
   input  logic [7:0] a5,
   input  logic [7:0] a4,
   input  logic [7:0] blend,
   input  logic [7:0] delay,
   input  logic [7:0] feedbk,
   input  logic [7:0] gain,
   output logic       busy,
   output logic       done,
   output logic       CTRL_TX
);

   localparam int CPB = fCLK / fBAUD;
   localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_n;
   logic [BW-1:0]   baud, baud_n;
   logic [2:0]      bit_idx, bit_n;
   logic [3:0]      byte_idx, byte_n;
   logic [7:0][7:0] snap;          // [0]=a8 .. [6]=gain, [7]=checksum
   logic [7:0]      cur;
   logic [7:0]      chk;
   logic            tx_n, busy_n, done_n;
   logic            last_clk;
   logic            accept;

   assign chk      = a8 ^ a5 ^ a4 ^ blend ^ delay ^ feedbk ^ gain;
   assign accept   = (state == IDLE) && go;
   assign last_clk = (baud == BW'(CPB - 1));
   // Byte 0 is the constant header; bytes 1..8 come from the snapshot.
   assign cur      = (byte_idx == 4'd0) ? SYNC : snap[3'(byte_idx - 4'd1)];

   always_comb begin
      state_n = state;
      baud_n  = baud;
      bit_n   = bit_idx;
      byte_n  = byte_idx;
      tx_n    = CTRL_TX;
      busy_n  = busy;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            tx_n   = 1'b1;
            busy_n = 1'b0;
            if (go) begin
               state_n = START;
               baud_n  = '0;
               byte_n  = 4'd0;
               tx_n    = 1'b0;
               busy_n  = 1'b1;
            end
         end
         START: begin
            if (last_clk) begin
               state_n = DATA;
               baud_n  = '0;
               bit_n   = 3'd0;
               tx_n    = cur[0];
            end else begin
               baud_n  = baud + 1'b1;
            end
         end
         DATA: begin
            if (last_clk) begin
               baud_n = '0;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_n = bit_idx + 3'd1;
                  tx_n  = cur[bit_idx + 3'd1];
               end
            end else begin
               baud_n = baud + 1'b1;
            end
         end
         STOP: begin
            if (last_clk) begin
               baud_n = '0;
               if (byte_idx < 4'd8) begin
                  state_n = START;
                  byte_n  = byte_idx + 4'd1;
                  tx_n    = 1'b0;
               end else begin
                  state_n = IDLE;
                  byte_n  = 4'd0;
                  tx_n    = 1'b1;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end
            end else begin
               baud_n = baud + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         baud     <= '0;
         bit_idx  <= 3'd0;
         byte_idx <= 4'd0;
         snap     <= '0;
         CTRL_TX  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         baud     <= baud_n;
         bit_idx  <= bit_n;
         byte_idx <= byte_n;
         CTRL_TX  <= tx_n;
         busy     <= busy_n;
         done     <= done_n;
         if (accept)
            snap <= {chk, gain, feedbk, delay, blend, a4, a5, a8};
      end
   end

endmodule

// File: tb/tb_ctrl_tx.sv
// Self-checking bench for ctrl_tx: table vectors, snapshot/ignored-go,
// back-to-back, mid-frame reset, random payloads, and a default-rate
// instance timed in parallel.
module tb_ctrl_tx;
   localparam int CPB = 10;

   logic clk = 1'b0;
   logic reset, go, busy, done, CTRL_TX;
   logic [7:0] a8, a5, a4, blend, delay, feedbk, gain;
   logic reset2, go2, busy2, done2, tx2;
   logic [7:0] zero8;

   int n_chk = 0, n_pass = 0, done_cnt = 0;
   bit def_fin = 1'b0;

   always #5 clk = ~clk;

   ctrl_tx #(.fCLK(1_000_000), .fBAUD(100_000)) dut (
      .clk(clk), .reset(reset), .go(go), .a8(a8), .a5(a5), .a4(a4),
      .blend(blend), .delay(delay), .feedbk(feedbk), .gain(gain),
      .busy(busy), .done(done), .CTRL_TX(CTRL_TX));

   ctrl_tx u_def (
      .clk(clk), .reset(reset2), .go(go2), .a8(zero8), .a5(zero8), .a4(zero8),
      .blend(zero8), .delay(zero8), .feedbk(zero8), .gain(zero8),
      .busy(busy2), .done(done2), .CTRL_TX(tx2));

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic set_in(input logic [6:0][7:0] d);
      a8 = d[0]; a5 = d[1]; a4 = d[2]; blend = d[3];
      delay = d[4]; feedbk = d[5]; gain = d[6];
   endtask

   // Reference: frame is a list of 9 bytes, each 10 line bits of CPB cycles.
   function automatic logic [7:0] model_byte(input logic [6:0][7:0] d, input int b);
      logic [7:0] x;
      if (b == 0) return 8'hA5;
      if (b <= 7) return d[b-1];
      x = 8'h00;
      for (int k = 0; k < 7; k++) x = x ^ d[k];
      return x;
   endfunction

   function automatic logic model_level(input logic [6:0][7:0] d, input int cyc);
      int j, pos;
      logic [7:0] by;
      j   = cyc / CPB;
      pos = j % 10;
      by  = model_byte(d, j / 10);
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return by[pos-1];
   endfunction

   // Starts at a negedge, raises go, follows the full frame and returns at
   // the negedge of the done cycle. ff_at >= 0 floods inputs with FF and
   // pulses go at that cycle of the frame.
   task automatic frame(input logic [6:0][7:0] d, input string nm, input bit keep_go,
                        input int ff_at, output logic [7:0] chk_dec);
      logic cap [900];
      int bad = 0, first = -1, frm = 0;
      logic [7:0] v;
      set_in(d);
      go = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!keep_go) go = 1'b0;
      for (int i = 0; i < 900; i++) begin
         cap[i] = CTRL_TX;
         if (CTRL_TX !== model_level(d, i) || busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            if (first < 0) first = i;
         end
         if (ff_at >= 0 && i == ff_at) begin
            set_in({7{8'hFF}});
            go = 1'b1;
         end else if (ff_at >= 0 && i == ff_at + 1) begin
            go = 1'b0;
         end
         @(negedge clk);
      end
      chk($sformatf("%s waveform bad cycles (first %0d)", nm, first), bad, 0);
      // UART monitor: mid-bit sampling of the captured line
      for (int b = 0; b < 9; b++) begin
         if (cap[b*10*CPB + CPB/2] !== 1'b0 || cap[(b*10+9)*CPB + CPB/2] !== 1'b1) frm++;
         for (int k = 0; k < 8; k++) v[k] = cap[(b*10+1+k)*CPB + CPB/2];
         if (v !== model_byte(d, b)) frm++;
         if (b == 8) chk_dec = v;
      end
      chk($sformatf("%s uart decode errors", nm), frm, 0);
      chk($sformatf("%s end busy/done/tx", nm), {busy, done, CTRL_TX}, 3'b011);
   endtask

   typedef struct {
      logic [6:0][7:0] d;
      logic [7:0]      chk;
   } vec_t;

   vec_t tbl [4];
   logic [7:0] cd;
   logic [6:0][7:0] rd;
   int dc0, idle_bad;

   initial begin
      tbl[0].d = {8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12}; tbl[0].chk = 8'hF0;
      tbl[1].d = '0;                                              tbl[1].chk = 8'h00;
      tbl[2].d = {7{8'hFF}};                                      tbl[2].chk = 8'hFF;
      tbl[3].d = {8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}; tbl[3].chk = 8'h7F;

      zero8 = 8'h00;
      reset = 1'b1; reset2 = 1'b1; go = 1'b0; go2 = 1'b0;
      set_in('0);
      repeat (3) @(negedge clk);
      chk("reset CTRL_TX", CTRL_TX, 1);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      reset = 1'b0; reset2 = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle after reset", {busy, done, CTRL_TX}, 3'b001);

      for (int t = 0; t < 4; t++) begin
         frame(tbl[t].d, $sformatf("vec%0d", t), 1'b0, -1, cd);
         chk($sformatf("vec%0d checksum", t), cd, tbl[t].chk);
         @(negedge clk);
         chk($sformatf("vec%0d idle after done", t), {busy, done}, 2'b00);
      end

      // Snapshot and ignored go mid-frame
      dc0 = done_cnt;
      frame(tbl[0].d, "snapshot", 1'b0, 300, cd);
      idle_bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0 || CTRL_TX !== 1'b1) idle_bad++;
      end
      chk("snapshot no second frame", idle_bad, 0);
      chk("snapshot single done", done_cnt - dc0, 1);

      // Back-to-back with go held high
      frame(tbl[0].d, "b2b0", 1'b1, -1, cd);
      frame(tbl[3].d, "b2b1", 1'b1, -1, cd);
      frame(tbl[2].d, "b2b2", 1'b1, -1, cd);
      go = 1'b0;
      @(negedge clk);
      chk("b2b stops when go drops", busy, 0);

      // Asynchronous reset during a data bit of byte 4
      set_in({8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77});
      go = 1'b1;
      @(posedge clk);
      @(negedge clk);
      go = 1'b0;
      repeat (445) @(negedge clk);
      chk("pre-reset busy", busy, 1);
      dc0 = done_cnt;
      #2 reset = 1'b1;
      #1;
      chk("async reset immediate", {busy, done, CTRL_TX}, 3'b001);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("post-reset idle", {busy, CTRL_TX}, 2'b01);
      chk("no done from aborted frame", done_cnt - dc0, 0);
      frame({8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, "post-reset", 1'b0, -1, cd);
      @(negedge clk);

      // Random payloads against the model
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < 7; k++) rd[k] = 8'($urandom);
         frame(rd, $sformatf("rand%0d", r), 1'b0, -1, cd);
         repeat (1 + $urandom_range(0, 3)) @(negedge clk);
      end

      for (int k = 0; k < 50000 && !def_fin; k++) @(negedge clk);
      if (!def_fin) chk("default-rate instance timeout", 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Default rate: 434 clk/bit, 39060-cycle frame
   initial begin
      int low, bcnt;
      repeat (6) @(negedge clk);
      go2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      go2 = 1'b0;
      low = 0;
      while (tx2 === 1'b0 && low < 1000) begin
         low++;
         @(negedge clk);
      end
      chk("default start bit length", low, 434);
      bcnt = low;
      while (busy2 === 1'b1 && bcnt < 40000) begin
         bcnt++;
         @(negedge clk);
      end
      chk("default frame length", bcnt, 39060);
      chk("default done pulse", done2, 1);
      def_fin = 1'b1;
   end
endmodule
